mac_frame_accum: RTL

Downstream stage of the multiply-add stage. Sums fixed-length frames of that stage's `data_out` results into one wide total per frame and holds each total behind a valid/ready output handshake. The upstream stage has no backpressure, so this block never stalls its input. Overruns are flagged, not prevented.

---
 rtl/mac_frame_accum_pkg.sv | 21 ++
 rtl/mac_frame_accum_sat_add.sv | 28 ++
 rtl/mac_frame_accum.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mac_frame_accum_pkg.sv
// rtl/mac_frame_accum_pkg.sv - shared types, defaults and helpers for mac_frame_accum
// Also provides the fallback for the shared DATA_WIDTH_OUT define.
`ifndef DATA_WIDTH_OUT
`define DATA_WIDTH_OUT 16
`endif

package mac_frame_accum_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam int DEF_N_TERMS = 8;
  localparam int ACC_MARGIN  = 8;

  function automatic int cnt_width(input int n_terms);
    return $clog2(n_terms);
  endfunction

endpackage

// File: rtl/mac_frame_accum_sat_add.sv
// rtl/mac_frame_accum_sat_add.sv - unsigned accumulate adder, clamping when MAC_FRAME_ACCUM_SATURATE_EN
// Without the macro the sum wraps and sat is tied low.
module sat_add #(
  parameter int ACC_WIDTH = 24,
  parameter int IN_WIDTH  = 16
) (
  input  logic [ACC_WIDTH-1:0] a,
  input  logic [IN_WIDTH-1:0]  b,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 sat
);

`ifdef MAC_FRAME_ACCUM_SATURATE_EN
  logic [ACC_WIDTH:0] full;

  always_comb begin
    full = {1'b0, a} + (ACC_WIDTH+1)'(b);
    sat  = full[ACC_WIDTH];
    sum  = full[ACC_WIDTH] ? '1 : full[ACC_WIDTH-1:0];
  end
`else
  always_comb begin
    sum = a + ACC_WIDTH'(b);
    sat = 1'b0;
  end
`endif

endmodule

// File: rtl/mac_frame_accum.sv
// rtl/mac_frame_accum.sv - sums N_TERMS-beat frames into a held total behind valid/ready
// Optional clamping on overflow with MAC_FRAME_ACCUM_SATURATE_EN.
`ifndef DATA_WIDTH_OUT
`define DATA_WIDTH_OUT 16
`endif

module mac_frame_accum
  import mac_frame_accum_pkg::*;
#(
  parameter int IN_WIDTH  = `DATA_WIDTH_OUT,
  parameter int ACC_WIDTH = IN_WIDTH + ACC_MARGIN,
  parameter int N_TERMS   = DEF_N_TERMS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  input  logic                 clear,
  input  logic                 ovr_clr,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sat,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = cnt_width(N_TERMS);
  localparam logic [CW-1:0] LAST_CNT = CW'(N_TERMS - 1);

  state_t               state, state_next;
  logic [CW-1:0]        count, count_next;
  logic [ACC_WIDTH-1:0] acc, acc_next;
  logic [ACC_WIDTH-1:0] add_a, sum;
  logic                 add_sat, frame_sat;
  logic                 accept, last_beat;

  // A frame's first beat adds to zero, so the total never carries stale acc.
  assign add_a = (state == IDLE) ? '0 : acc;

  sat_add #(
    .ACC_WIDTH(ACC_WIDTH),
    .IN_WIDTH (IN_WIDTH)
  ) u_add (
    .a  (add_a),
    .b  (in_data),
    .sum(sum),
    .sat(add_sat)
  );

  assign accept    = in_valid && !clear;
  assign last_beat = accept && (state == ACCUM) && (count == LAST_CNT);

  always_comb begin
    state_next = state;
    count_next = count;
    acc_next   = acc;
    if (clear) begin
      state_next = IDLE;
      count_next = '0;
      acc_next   = '0;
    end else if (accept) begin
      if (last_beat) begin
        state_next = IDLE;
        count_next = '0;
        acc_next   = '0;
      end else begin
        state_next = ACCUM;
        count_next = count + CW'(1);
        acc_next   = sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      acc   <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      acc   <= acc_next;
    end
  end

`ifdef MAC_FRAME_ACCUM_SATURATE_EN
  logic sat_acc;

  // Sticky within a frame: adding zero to a clamped acc must still report clamp.
  assign frame_sat = sat_acc | add_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_acc <= 1'b0;
      out_sat <= 1'b0;
    end else begin
      if (clear || last_beat) sat_acc <= 1'b0;
      else if (accept)        sat_acc <= frame_sat;
      if (last_beat)          out_sat <= frame_sat;
    end
  end
`else
  assign frame_sat = add_sat;
  assign out_sat   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy    <= (state_next == ACCUM);
      overrun <= (last_beat && out_valid && !out_ready) || (overrun && !ovr_clr);
      if (last_beat) begin
        out_data  <= sum;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
